// File: rtl/lstm_pkg.sv
// Shared types, sizes and helpers for the LSTM gate pre-activation MAC.
// Optional build macro PREACT_ROUND_EN (used by mac_lane) selects
// round-half-up at finalize instead of floor truncation.
package lstm_pkg;

    localparam int X_LEN     = 100;
    localparam int H_LEN     = 100;
    localparam int IN_LEN    = X_LEN + H_LEN;
    localparam int OUT_LEN   = 400;
    localparam int LANES     = 4;
    localparam int FRAC_BITS = 16;

    localparam int DATA_W    = 32;
    localparam int COEF_W    = 32;
    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int ACC_W     = 72;
    localparam int ADDR_W    = 15;

    localparam int GROUPS    = OUT_LEN / LANES;
    localparam int G_W       = $clog2(GROUPS);
    localparam int K_W       = $clog2(IN_LEN);

    typedef logic signed [DATA_W-1:0] word_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    // Clamp a wide signed value into the 32-bit signed range.
    function automatic word_t sat32(input acc_t v);
        logic [ACC_W-DATA_W:0] hi;
        hi = v[ACC_W-1:DATA_W-1];
        if (hi == '0 || hi == '1)
            sat32 = word_t'(v[DATA_W-1:0]);
        else if (v[ACC_W-1])
            sat32 = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat32 = {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: loads on the first column beat, accumulates, and on the
// last column beat produces the biased, scaled and saturated row result.
// PREACT_ROUND_EN: add half an LSB before the fractional shift.
module mac_lane
    import lstm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              vld,
    input  logic              first,
    input  logic              last,
    input  logic [COEF_W-1:0] w,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] bias,
    output logic              fin,
    output logic [DATA_W-1:0] res
);

    word_t w_s;
    word_t x_s;
    word_t bias_s;
    prod_t prod_p1;
    acc_t  acc;
    acc_t  sum_p1;
    acc_t  scaled_p1;

    // Drop the fractional bits of the Q15.16 x Q15.16 product sum.
    function automatic acc_t shift_frac(input acc_t v);
`ifdef PREACT_ROUND_EN
        shift_frac = (v + (acc_t'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
`else
        shift_frac = v >>> FRAC_BITS;
`endif
    endfunction

    assign w_s    = w;
    assign x_s    = x;
    assign bias_s = bias;

    // p1: ROM beat and operand are aligned; form product and running sum
    assign prod_p1   = prod_t'(w_s) * prod_t'(x_s);
    assign sum_p1    = (first ? acc_t'(0) : acc) + acc_t'(prod_p1);
    assign scaled_p1 = shift_frac(sum_p1) + acc_t'(bias_s);

    assign fin = vld & last;
    assign res = sat32(scaled_p1);

    // Accumulator: restart on column 0, otherwise add the new product.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (vld)
            acc <= sum_p1;
    end

endmodule

// File: rtl/gate_preact_mac.sv
// Gate pre-activation MAC for the LSTM fgio stage: fgio_out[j] =
// bias[j] + sum_k W[j][k]*xh[k], LANES rows at a time, weights streamed
// from a 1-cycle-latency ROM. Build macro PREACT_ROUND_EN selects
// round-half-up at finalize (see mac_lane); default is floor.
module gate_preact_mac
    import lstm_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_W*X_LEN-1:0]   x_in,
    input  logic [DATA_W*H_LEN-1:0]   h_in,
    input  logic [DATA_W*OUT_LEN-1:0] bias_in,
    output logic                      w_rd_en,
    output logic [ADDR_W-1:0]         w_addr,
    input  logic [COEF_W*LANES-1:0]   w_rdata,
    output logic                      busy,
    output logic                      done,
    output logic                      fgio_valid,
    output logic [DATA_W*OUT_LEN-1:0] fgio_out
);

    state_t             state;
    logic [G_W-1:0]     g_p0;
    logic [K_W-1:0]     k_p0;
    logic [G_W-1:0]     g_p1;
    logic [K_W-1:0]     k_p1;
    logic               vld_p1;
    logic               last_addr;
    logic               first_p1;
    logic               last_p1;
    word_t              x_p1;
    word_t              xh_reg   [IN_LEN];
    word_t              fgio_mem [OUT_LEN];
    logic [LANES-1:0]   fin;
    logic [DATA_W-1:0]  res      [LANES];

    assign last_addr = (g_p0 == G_W'(GROUPS - 1)) && (k_p0 == K_W'(IN_LEN - 1));

    // p0: sequencer issuing one ROM address per RUN cycle, plus status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            fgio_valid <= 1'b0;
            w_rd_en    <= 1'b0;
            w_addr     <= '0;
            g_p0       <= '0;
            k_p0       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        fgio_valid <= 1'b0;
                        w_rd_en    <= 1'b1;
                        w_addr     <= '0;
                        g_p0       <= '0;
                        k_p0       <= '0;
                    end
                end
                RUN: begin
                    if (last_addr) begin
                        state   <= DRAIN;
                        w_rd_en <= 1'b0;
                    end else begin
                        w_addr <= w_addr + ADDR_W'(1);
                        if (k_p0 == K_W'(IN_LEN - 1)) begin
                            k_p0 <= '0;
                            g_p0 <= g_p0 + G_W'(1);
                        end else begin
                            k_p0 <= k_p0 + K_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    state      <= FIN;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    fgio_valid <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the input vector when a run is accepted; held for the whole run.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int k = 0; k < X_LEN; k++)
                xh_reg[k] <= x_in[k*DATA_W +: DATA_W];
            for (int k = 0; k < H_LEN; k++)
                xh_reg[X_LEN + k] <= h_in[k*DATA_W +: DATA_W];
        end
    end

    // p1: delay the address-phase tags so they line up with the ROM beat.
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= w_rd_en;
        g_p1 <= g_p0;
        k_p1 <= k_p0;
    end

    assign x_p1     = xh_reg[k_p1];
    assign first_p1 = (k_p1 == '0);
    assign last_p1  = (k_p1 == K_W'(IN_LEN - 1));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .vld   (vld_p1),
            .first (first_p1),
            .last  (last_p1),
            .w     (w_rdata[l*COEF_W +: COEF_W]),
            .x     (x_p1),
            .bias  (bias_in[(int'(g_p1)*LANES + l)*DATA_W +: DATA_W]),
            .fin   (fin[l]),
            .res   (res[l])
        );
    end

    // p2: commit each finished lane result into its row of the output bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < OUT_LEN; j++)
                fgio_mem[j] <= '0;
        end else begin
            for (int l = 0; l < LANES; l++)
                if (fin[l])
                    fgio_mem[int'(g_p1)*LANES + l] <= res[l];
        end
    end

    for (genvar j = 0; j < OUT_LEN; j++) begin : g_out
        assign fgio_out[j*DATA_W +: DATA_W] = fgio_mem[j];
    end

endmodule

// File: doc/gate_preact_mac.md
Name: gate_preact_mac

Overview:
- Upstream stage of the LSTM cell's fgio nonlinear/state stage. Computes the 400 gate pre-activations consumed by that stage: fgio_out[j] = bias[j] + sum_k W[j][k]*xh[k], where xh = {x_in[0:99], h_in[0:99]}.
- Rows are ordered f, g, i, o, 100 each.
- Time-multiplexed MAC over LANES parallel rows. Weights are streamed from an external synchronous ROM.

Parameters:
- X_LEN, 100, input vector length.
- H_LEN, 100, hidden vector length. IN_LEN = X_LEN + H_LEN = 200.
- OUT_LEN, 400, number of gate pre-activations. Must be a multiple of LANES.
- LANES, 4, rows computed in parallel.
- FRAC_BITS, 16, fractional bits of the signed 32-bit fixed-point format (Q15.16).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a computation; sampled only in IDLE.
- x_in  in  32 x X_LEN  signed input vector; latched on an accepted start.
- h_in  in  32 x H_LEN  signed previous hidden state; latched on an accepted start.
- bias_in  in  32 x OUT_LEN  signed biases; must be held stable while busy.
- w_rd_en  out  1  weight ROM read enable.
- w_addr  out  15  ROM word address = g*IN_LEN + k (g = row group, k = column).
- w_rdata  in  32 x LANES  ROM data, 1-cycle read latency. Lane l holds W[g*LANES+l][k].
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse when all outputs are written.
- fgio_valid  out  1  high from done until the next accepted start or reset.
- fgio_out  out  32 x OUT_LEN  signed pre-activations; feeds the fgio stage's gate input.

Behaviour:
- Reset values: every output is 0, including all fgio_out words. FSM goes to IDLE. Internal accumulators are cleared.
- FSM states:
  - IDLE: start=1 latches x_in/h_in into xh_reg, sets busy, and moves to RUN. fgio_valid clears on this same edge.
  - RUN: each cycle issues w_rd_en=1 with w_addr for (g,k). k counts 0..IN_LEN-1, then wraps and g increments. After the final address (g=OUT_LEN/LANES-1, k=IN_LEN-1) the FSM moves to DRAIN.
  - DRAIN: one cycle to absorb the last ROM beat. Moves to FIN.
  - FIN: the last group is written. done=1 for this cycle, fgio_valid=1, busy=0. Moves to IDLE.
- Datapath pipeline: the ROM beat for (g,k) arrives one cycle after its address. Each lane computes the 64-bit signed product w_rdata[l]*xh_reg[k] and adds it into a 72-bit signed accumulator.
  - On the beat with k=0, the accumulator loads the product instead of adding it.
  - On the beat with k=IN_LEN-1, the lane finalizes.
- Finalize, per lane: r = (acc >>> FRAC_BITS) + sign-extended bias. The shift is arithmetic (floor). r is saturated to [0x80000000, 0x7FFFFFFF] and written to fgio_out[g*LANES+l] on the next edge.
- Groups are back-to-back with no bubble between them.
- Latency: start accepted at edge 0; w_rd_en high on cycles 1..N with N = (OUT_LEN/LANES)*IN_LEN = 20000; done at cycle N+2 = 20002.
- While busy, fgio_out words update group by group. Consumers must use only fgio_valid/done.
- start while busy is ignored. start held high in IDLE launches one run per IDLE entry.
- rst at any cycle aborts the run with reset values on the next edge. No residual done pulse is produced.
- w_rd_en=0 in IDLE, DRAIN and FIN. w_addr holds its last value when w_rd_en=0.

Optional Feature:
- Macro PREACT_ROUND_EN.
- Defined: at finalize, 1<<(FRAC_BITS-1) is added to acc before the shift (round half up toward +inf), then saturation is applied.
- Undefined: truncation (floor), as specified above.
- Latency is identical in both builds.

Decomposition:
- Package lstm_pkg holds:
  - parameters X_LEN, H_LEN, IN_LEN, OUT_LEN, LANES, FRAC_BITS;
  - typedefs word_t (signed 32), prod_t (signed 64), acc_t (signed 72);
  - enum state_t {IDLE, RUN, DRAIN, FIN};
  - function sat32(acc_t) returning word_t.
- One sub-module: mac_lane (load/accumulate/finalize for one row), instantiated LANES times via generate.

Test Plan:
- All weights 0, bias[j]=j, x=h=arbitrary → fgio_out[j]=j for all 400; done exactly at cycle 20002; busy high cycles 1..20001.
- All weights 0x00010000, x=h=0x00010000, bias 0 → every fgio_out = 0x00C80000 (200.0).
- Saturation: all W=x=h=0x7FFFFFFF → all outputs 0x7FFFFFFF. Same with x=h=0x80000001 → all 0x80000000.
- Rounding: W[0][0]=1, x[0]=0x8000, all else 0 → fgio_out[0]=0 without macro, 1 with PREACT_ROUND_EN. With x[0]=-0x8000 → -1 without macro, 0 with it.
- Protocol: pulse start at cycle 100 while busy → ignored; done count = 1. Assert rst at cycle 5000 → busy=0, fgio_valid=0, all outputs 0, no done pulse. A new start then completes correctly in 20002 cycles.
- ROM address check: scoreboard requires w_addr to step 0..19999 contiguously with w_rd_en high exactly 20000 cycles per run.
